bf16_to_int_pipe: RTL and testbench

Pipelined, multi-lane BF16-to-integer converter with valid/ready flow control, selectable rounding mode, signed/unsigned result and saturating overflow handling. It is the native, parametrised successor to the fpnew-based BF16 integer cast and sits between BF16 datapaths and integer consumers (index generation, quantisation, exponent tables). Fixed 2-cycle latency; full throughput of one vector per cycle.

---
 rtl/bf16_to_int_pipe.sv | 196 +++++++++++++++++++
 tb/tb_bf16_to_int_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_to_int_pipe.sv
// bf16_to_int_pipe: two-stage elastic BF16 -> integer converter, LANES lanes of INT_W-bit results.
// Define BF16_INT_FLAGS_EN to build the per-lane {NV, NX} flags; otherwise out_flags is tied to 0.
module bf16_to_int_pipe #(
    parameter int LANES = 1,
    parameter int INT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [16*LANES-1:0]    in_data,
    input  logic [1:0]             in_rm,
    input  logic                   in_signed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INT_W*LANES-1:0] out_data,
    output logic [2*LANES-1:0]     out_flags
);

    // Alignment window: INT_W+1 integer bits above FB fraction bits (guard is the top fraction bit).
    localparam int FB = 10;
    localparam int XW = INT_W + 1 + FB;

    localparam logic [INT_W+1:0] ONE_W  = {{(INT_W+1){1'b0}}, 1'b1};
    localparam logic [INT_W+1:0] LIM_SN = ONE_W << (INT_W - 1);
    localparam logic [INT_W+1:0] LIM_SP = LIM_SN - ONE_W;
    localparam logic [INT_W+1:0] LIM_U  = (ONE_W << INT_W) - ONE_W;
    localparam logic [INT_W-1:0] MAX_S  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] MIN_S  = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] MAX_U  = {INT_W{1'b1}};

    typedef struct packed {
        logic           sign;
        logic           nan;
        logic           inf;
        logic           ovf;
        logic [INT_W:0] mag;
        logic           g;
        logic           rs;
    } align_t;

    function automatic align_t align_lane(input logic [15:0] x);
        align_t        a;
        logic [XW-1:0] x0;
        logic [XW-1:0] xs;
        logic          lost;
        int            sh;
        a      = '0;
        a.sign = x[15];
        x0     = {{(XW-8){1'b0}}, 1'b1, x[6:0]} << (FB - 7);
        xs     = '0;
        lost   = 1'b0;
        sh     = int'(x[14:7]) - 127;
        if (x[14:7] == 8'hFF) begin
            a.nan = (x[6:0] != 7'd0);
            a.inf = (x[6:0] == 7'd0);
        end else if (x[14:7] == 8'h00) begin
            // Subnormals sit far below one quarter: only sticky can be set.
            a.rs = (x[6:0] != 7'd0);
        end else if (sh > INT_W) begin
            a.ovf = 1'b1;
        end else begin
            if (sh >= 0) begin
                xs = x0 << sh;
            end else if (-sh < XW) begin
                xs   = x0 >> (-sh);
                lost = ((xs << (-sh)) != x0);
            end else begin
                lost = 1'b1;
            end
            a.mag = xs[XW-1:FB];
            a.g   = xs[FB-1];
            a.rs  = (|xs[FB-2:0]) | lost;
        end
        return a;
    endfunction

    function automatic logic [INT_W+1:0] round_mag(input align_t a, input logic [1:0] rm);
        logic inc;
        case (rm)
            2'd0:    inc = a.g & (a.rs | a.mag[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = a.sign & (a.g | a.rs);
            default: inc = ~a.sign & (a.g | a.rs);
        endcase
        return {1'b0, a.mag} + {{(INT_W+1){1'b0}}, inc};
    endfunction

    function automatic logic [INT_W-1:0] sat_val(input align_t a, input logic [1:0] rm,
                                                 input logic sgn);
        logic [INT_W+1:0] m;
        logic [INT_W-1:0] pos_max;
        logic [INT_W-1:0] neg_lim;
        m       = round_mag(a, rm);
        pos_max = sgn ? MAX_S : MAX_U;
        neg_lim = sgn ? MIN_S : '0;
        if (a.nan) return pos_max;
        if (a.inf | a.ovf) return a.sign ? neg_lim : pos_max;
        if (!a.sign) return (m > (sgn ? LIM_SP : LIM_U)) ? pos_max : m[INT_W-1:0];
        if (!sgn) return '0;
        return (m > LIM_SN) ? MIN_S : -m[INT_W-1:0];
    endfunction

`ifdef BF16_INT_FLAGS_EN
    function automatic logic [1:0] lane_flags(input align_t a, input logic [1:0] rm,
                                              input logic sgn);
        logic [INT_W+1:0] m;
        logic             nx;
        m  = round_mag(a, rm);
        nx = a.g | a.rs;
        if (a.nan | a.inf | a.ovf) return 2'b10;
        if (!a.sign) return (m > (sgn ? LIM_SP : LIM_U)) ? 2'b10 : {1'b0, nx};
        if (sgn) return (m > LIM_SN) ? 2'b10 : {1'b0, nx};
        return (m != '0) ? 2'b10 : {1'b0, nx};
    endfunction
`endif

    logic vld_p1_q, vld_p1_d;
    logic vld_p2_q, vld_p2_d;
    logic ld_p1, ld_p2;

    assign ld_p2    = ~vld_p2_q | out_ready;
    assign in_ready = ~vld_p1_q | ld_p2;
    assign ld_p1    = in_valid & in_ready;

    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        if (in_ready) vld_p1_d = in_valid;
        if (ld_p2)    vld_p2_d = vld_p1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // Stage 1: decode and align each lane.
    align_t     aln_p1_q [LANES];
    logic [1:0] rm_p1_q;
    logic       sgn_p1_q;

    always_ff @(posedge clk) begin
        if (ld_p1) begin
            for (int i = 0; i < LANES; i++) aln_p1_q[i] <= align_lane(in_data[16*i +: 16]);
            rm_p1_q  <= in_rm;
            sgn_p1_q <= in_signed;
        end
    end

    // Stage 2: round, apply sign and saturate.
    logic [INT_W*LANES-1:0] data_p2_d, data_p2_q;

    always_comb begin
        data_p2_d = data_p2_q;
        if (ld_p2 & vld_p1_q) begin
            for (int i = 0; i < LANES; i++)
                data_p2_d[INT_W*i +: INT_W] = sat_val(aln_p1_q[i], rm_p1_q, sgn_p1_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_p2_q <= '0;
        else     data_p2_q <= data_p2_d;
    end

`ifdef BF16_INT_FLAGS_EN
    logic [2*LANES-1:0] flags_p2_d, flags_p2_q;

    always_comb begin
        flags_p2_d = flags_p2_q;
        if (ld_p2 & vld_p1_q) begin
            for (int i = 0; i < LANES; i++)
                flags_p2_d[2*i +: 2] = lane_flags(aln_p1_q[i], rm_p1_q, sgn_p1_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_p2_q <= '0;
        else     flags_p2_q <= flags_p2_d;
    end

    assign out_flags = flags_p2_q;
`else
    assign out_flags = '0;
`endif

    assign out_valid = vld_p2_q;
    assign out_data  = data_p2_q;

endmodule

// File: tb/tb_bf16_to_int_pipe.sv
// tb_bf16_to_int_pipe: directed and randomized checks of bf16_to_int_pipe (LANES=4, INT_W=16)
// against a real-arithmetic reference model and an in-order scoreboard.
module tb_bf16_to_int_pipe;

    localparam int LANES = 4;
    localparam int INT_W = 16;
    localparam int DW    = INT_W * LANES;
`ifdef BF16_INT_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [16*LANES-1:0]  in_data;
    logic [1:0]           in_rm;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [2*LANES-1:0]   out_flags;

    bf16_to_int_pipe #(.LANES(LANES), .INT_W(INT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rm     (in_rm),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]      d;
        logic [2*LANES-1:0] f;
        logic               dir;
        logic [INT_W-1:0]   dv;
        logic [1:0]         df;
        string              nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_blocked = 0;
    bit   rnd_done  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact real value, rounded by mode, then clipped to the integer range.
    function automatic logic [INT_W+1:0] ref_lane(input logic [15:0] x, input logic [1:0] rm,
                                                  input logic sg);
        int   e;
        real  mag, ip, fr, r, maxp, minn;
        logic [INT_W-1:0] v;
        e    = int'(x[14:7]);
        maxp = sg ? $pow(2.0, real'(INT_W - 1)) - 1.0 : $pow(2.0, real'(INT_W)) - 1.0;
        minn = sg ? -$pow(2.0, real'(INT_W - 1)) : 0.0;
        if (e == 255) begin
            if (x[6:0] != 7'd0 || !x[15]) return {2'b10, INT_W'(longint'(maxp))};
            return {2'b10, INT_W'(longint'(minn))};
        end
        if (e == 0) mag = real'(int'(x[6:0])) * $pow(2.0, -133.0);
        else        mag = real'(128 + int'(x[6:0])) * $pow(2.0, real'(e - 134));
        ip = $floor(mag);
        fr = mag - ip;
        case (rm)
            2'd0: if (fr > 0.5 || (fr == 0.5 && $floor(ip / 2.0) * 2.0 != ip)) ip = ip + 1.0;
            2'd1: ip = ip;
            2'd2: if (x[15] && fr > 0.0) ip = ip + 1.0;
            default: if (!x[15] && fr > 0.0) ip = ip + 1.0;
        endcase
        r = x[15] ? -ip : ip;
        if (r > maxp) return {2'b10, INT_W'(longint'(maxp))};
        if (r < minn) return {2'b10, INT_W'(longint'(minn))};
        v = INT_W'(longint'(r));
        return {1'b0, (fr > 0.0), v};
    endfunction

    function automatic exp_t make_exp(input logic [16*LANES-1:0] d, input logic [1:0] rm,
                                      input logic sg);
        exp_t             e;
        logic [INT_W+1:0] r;
        e.d = '0; e.f = '0; e.dir = 1'b0; e.dv = '0; e.df = '0; e.nm = "";
        for (int i = 0; i < LANES; i++) begin
            r = ref_lane(d[16*i +: 16], rm, sg);
            e.d[INT_W*i +: INT_W] = r[INT_W-1:0];
            e.f[2*i +: 2]         = FLAGS_ON ? r[INT_W+1:INT_W] : 2'b00;
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] x;
        int          k;
        x = 16'($urandom);
        k = $urandom_range(0, 9);
        if (k < 6)       x[14:7] = 8'($urandom_range(118, 145));
        else if (k == 6) x[14:7] = 8'hFF;
        else if (k == 7) x[14:7] = 8'h00;
        return x;
    endfunction

    function automatic logic [16*LANES-1:0] vec_with(input logic [15:0] x0);
        logic [16*LANES-1:0] v;
        v = '0;
        v[15:0] = x0;
        for (int i = 1; i < LANES; i++) v[16*i +: 16] = rand_bf16();
        return v;
    endfunction

    task automatic send(input logic [16*LANES-1:0] d, input logic [1:0] rm, input logic sg,
                        input logic dir, input logic [INT_W-1:0] dv, input logic [1:0] df,
                        input string nm);
        exp_t e;
        int   n;
        e     = make_exp(d, rm, sg);
        e.dir = dir; e.dv = dv; e.df = df; e.nm = nm;
        in_data = d; in_rm = rm; in_signed = sg; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        else           sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic dir(input logic [15:0] x, input logic [1:0] rm, input logic sg,
                       input logic [15:0] v, input logic [1:0] f, input string nm);
        send(vec_with(x), rm, sg, 1'b1, INT_W'(v), f, nm);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic latency_probe(input string nm);
        dir(16'h4040, 2'd0, 1'b1, 16'h0003, 2'b00, nm);
        @(negedge clk);
        check("latency_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    // Output monitor: in-order scoreboard plus hold-stability under stall.
    logic [DW-1:0]      held_d;
    logic [2*LANES-1:0] held_f;
    bit                 held_v = 1'b0;
    exp_t               mon_e;

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (in_valid && !in_ready) n_blocked++;
            if (out_valid) begin
                if (held_v) begin
                    check("stall_data", 64'(out_data), 64'(held_d));
                    check("stall_flags", 64'(out_flags), 64'(held_f));
                end
                if (out_ready) begin
                    held_v = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_out", 64'(out_valid), 64'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("out_data", 64'(out_data), 64'(mon_e.d));
                        check("out_flags", 64'(out_flags), 64'(mon_e.f));
                        if (mon_e.dir) begin
                            check(mon_e.nm, 64'(out_data[INT_W-1:0]), 64'(mon_e.dv));
                            check({mon_e.nm, "_flags"}, 64'(out_flags[1:0]),
                                  64'(FLAGS_ON ? mon_e.df : 2'b00));
                        end
                    end
                end else begin
                    held_v = 1'b1;
                    held_d = out_data;
                    held_f = out_flags;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d outputs still pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int blk0;
        in_valid = 1'b0; in_data = '0; in_rm = 2'd0; in_signed = 1'b1; out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_flags", 64'(out_flags), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        latency_probe("lat_3p0");
        drain();

        // Directed values, streamed back to back.
        dir(16'h3FC0, 2'd0, 1'b1, 16'h0002, 2'b01, "rne_1p5");
        dir(16'h4020, 2'd0, 1'b1, 16'h0002, 2'b01, "rne_2p5");
        dir(16'hBFC0, 2'd1, 1'b1, 16'hFFFF, 2'b01, "rtz_m1p5");
        dir(16'hBFC0, 2'd2, 1'b1, 16'hFFFE, 2'b01, "rdn_m1p5");
        dir(16'hBFC0, 2'd3, 1'b1, 16'hFFFF, 2'b01, "rup_m1p5");
        dir(16'h7FC0, 2'd0, 1'b1, 16'h7FFF, 2'b10, "nan_s");
        dir(16'h4780, 2'd0, 1'b1, 16'h7FFF, 2'b10, "ovf_65536_s");
        dir(16'hC700, 2'd0, 1'b1, 16'h8000, 2'b00, "min_s");
        dir(16'hFF80, 2'd0, 1'b1, 16'h8000, 2'b10, "ninf_s");
        dir(16'h0001, 2'd3, 1'b1, 16'h0001, 2'b01, "subn_rup");
        dir(16'h477F, 2'd0, 1'b0, 16'hFF00, 2'b00, "u_65280");
        dir(16'hBF80, 2'd0, 1'b0, 16'h0000, 2'b10, "u_m1");
        dir(16'hBE80, 2'd0, 1'b0, 16'h0000, 2'b01, "u_m0p25");
        dir(16'h8000, 2'd0, 1'b1, 16'h0000, 2'b00, "neg_zero");
        dir(16'h7F80, 2'd0, 1'b0, 16'hFFFF, 2'b10, "u_pinf");
        dir(16'h7FC0, 2'd0, 1'b0, 16'hFFFF, 2'b10, "u_nan");
        dir(16'hFF80, 2'd0, 1'b0, 16'h0000, 2'b10, "u_ninf");
        drain();

        // Backpressure: out_ready low for four cycles while six vectors stream in.
        blk0 = n_blocked;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send({rand_bf16(), rand_bf16(), rand_bf16(), rand_bf16()}, 2'd0, 1'b1,
                         1'b0, '0, 2'b00, "bp");
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_low", 64'(n_blocked > blk0), 64'd1);

        // Randomized traffic with random backpressure and input gaps.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end
                    send({rand_bf16(), rand_bf16(), rand_bf16(), rand_bf16()},
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         1'b0, '0, 2'b00, "rnd");
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Reset with two transactions in flight.
        send(vec_with(16'h4040), 2'd0, 1'b1, 1'b0, '0, 2'b00, "inflight0");
        send(vec_with(16'h4100), 2'd0, 1'b1, 1'b0, '0, 2'b00, "inflight1");
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(out_valid), 64'd0);
        latency_probe("lat_after_rst");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
